marks_access_ctrl: RTL and testbench
====================================

Name: marks_access_ctrl

Overview:
- Sequences and arbitrates access to the shared college mark registers (math, physics, lab) between teacher, principal and student requesters.
- Owns the three 8-bit mark registers.
- Enforces role permissions and a publication phase order: teacher enters marks, principal reviews/adjusts lab, then students read.
- Sits between the role-side agents and the college interface signals.

Parameters:
- DATA_W, 8, mark width in bits.
- MAX_MARK, 100, largest legal mark value; writes above it are rejected.

Ports:
- clk input 1 system clock, rising edge.
- rst_n input 1 asynchronous active-low reset.
- t_req input 1 teacher write request; held until t_gnt or t_err.
- t_sel input 2 teacher subject select (0 math, 1 physics, 2 lab, 3 invalid).
- t_wdata input DATA_W teacher write data.
- t_gnt output 1 teacher write accepted, 1-cycle pulse.
- t_err output 1 teacher request rejected, 1-cycle pulse.
- p_req input 1 principal request.
- p_we input 1 principal write (1) / read (0).
- p_sel input 2 principal subject select.
- p_wdata input DATA_W principal write data.
- p_gnt output 1 principal grant pulse.
- p_err output 1 principal reject pulse.
- p_rdata output DATA_W principal read data, valid while p_gnt=1.
- p_approve input 1 principal releases marks to students (pulse).
- s_req input 1 student read request.
- s_sel input 2 student subject select.
- s_gnt output 1 student grant pulse.
- s_err output 1 student reject pulse.
- s_rdata output DATA_W student read data, valid while s_gnt=1.
- term_clr input 1 start new term: clear marks, return to ENTRY.
- phase output 2 current phase (0 ENTRY, 1 REVIEW, 2 RELEASE).
- math_q, phys_q, lab_q output DATA_W each: live mark register values.

Behaviour:
- Reset (async, rst_n=0): marks=0, phase=ENTRY, written mask=3'b000, all gnt/err=0, rdata=0, round-robin pointer favours principal.
- Handshake:
  - Requests are sampled on clock edge N; gnt or err is registered and asserts for exactly one cycle at N+1.
  - A write updates the register at the same edge that raises gnt.
  - rdata is registered with gnt and holds its last value otherwise.
  - A requester drops req in the gnt/err cycle; req still high in that cycle is a new request.
  - req may be withdrawn before grant with no side effect.
- Reject rules: err instead of gnt, and no state change, when any of these hold:
  - sel==3.
  - A write with wdata>MAX_MARK.
  - Teacher request in REVIEW or RELEASE.
  - Principal write with sel!=2.
  - Any principal write in RELEASE.
- Stall rules: no gnt and no err, req stays pending, for:
  - Principal request in ENTRY.
  - Student request in ENTRY or REVIEW.
- ENTRY:
  - Only the teacher is served.
  - Each granted write sets mask[sel]; rewrites are allowed.
  - When the mask reaches 3'b111 on a grant edge, phase becomes REVIEW on the next edge.
- REVIEW:
  - Only the principal is served: reads of any subject, writes to lab only.
  - A p_approve pulse moves phase to RELEASE on the next edge.
  - If a lab write and p_approve arrive in the same cycle, the write completes and the phase still advances.
  - p_approve outside REVIEW is ignored.
- RELEASE:
  - Principal reads and student reads share one grant per cycle via 2-way round-robin.
  - The pointer moves to the other requester after each grant.
  - With a single requester, it is granted every request.
- term_clr:
  - Highest priority over every other event in the cycle, including p_approve.
  - No gnt is issued for that cycle's requests.
  - Next edge: marks=0, mask=0, phase=ENTRY; pending requests are re-evaluated afterwards.
  - Pending principal/student requests then stall.
- Asynchronous reset asserted mid-transaction aborts it: no gnt is issued and the register is unchanged by the aborted write.
- Width: wdata stored unmodified, with no saturation; comparison against MAX_MARK is unsigned.

Decomposition:
- Package marks_pkg holds:
  - phase_e enum: ENTRY, REVIEW, RELEASE.
  - subj_e enum: MATH=0, PHYS=1, LAB=2, BAD=3.
  - MAX_MARK default and DATA_W default.
- Sub-module rr_arb2: 2-requester round-robin arbiter with a registered last-grant pointer, used in RELEASE.

Test Plan:
- After reset, teacher writes math=85, phys=90, lab=95 -> each t_gnt 1 cycle after req; phase=REVIEW after the third grant; math_q/phys_q/lab_q=85/90/95.
- In ENTRY, student reads sel=0 and teacher writes sel=1 value 101 -> s_gnt stays 0 (stall); t_err pulses; phys_q unchanged.
- In REVIEW:
  - Principal reads math -> p_rdata=85 with p_gnt.
  - Principal writes math=70 -> p_err, math_q=85.
  - Principal writes lab=99 together with p_approve -> p_gnt, lab_q=99, phase=RELEASE.
- In RELEASE, principal and student hold reads of lab for 4 cycles -> grants alternate P,S,P,S (one per cycle), each rdata=99; principal write -> p_err.
- term_clr together with p_approve in REVIEW -> phase=ENTRY, all marks 0, mask cleared, no grants that cycle.
- rst_n pulsed low asynchronously mid-cycle during a pending teacher write -> all outputs 0 immediately, phase=ENTRY, no t_gnt.

Source files
------------

// File: rtl/marks_access_ctrl_pkg.sv
// Shared types and defaults for the mark-register access controller.
package marks_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int MAX_MARK_DEF = 100;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    REVIEW  = 2'd1,
    RELEASE = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    MATH = 2'd0,
    PHYS = 2'd1,
    LAB  = 2'd2,
    BAD  = 2'd3
  } subj_e;

endpackage

// File: rtl/marks_access_ctrl_if.sv
// Role-side request/grant bundle plus the live mark/phase view.
interface marks_access_ctrl_if
  import marks_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic              t_req;
  logic [1:0]        t_sel;
  logic [DATA_W-1:0] t_wdata;
  logic              t_gnt;
  logic              t_err;

  logic              p_req;
  logic              p_we;
  logic [1:0]        p_sel;
  logic [DATA_W-1:0] p_wdata;
  logic              p_gnt;
  logic              p_err;
  logic [DATA_W-1:0] p_rdata;
  logic              p_approve;

  logic              s_req;
  logic [1:0]        s_sel;
  logic              s_gnt;
  logic              s_err;
  logic [DATA_W-1:0] s_rdata;

  logic              term_clr;
  logic [1:0]        phase;
  logic [DATA_W-1:0] math_q;
  logic [DATA_W-1:0] phys_q;
  logic [DATA_W-1:0] lab_q;

  modport master (
    output t_req, t_sel, t_wdata,
    input  t_gnt, t_err,
    output p_req, p_we, p_sel, p_wdata, p_approve,
    input  p_gnt, p_err, p_rdata,
    output s_req, s_sel,
    input  s_gnt, s_err, s_rdata,
    output term_clr,
    input  phase, math_q, phys_q, lab_q
  );

  modport slave (
    input  t_req, t_sel, t_wdata,
    output t_gnt, t_err,
    input  p_req, p_we, p_sel, p_wdata, p_approve,
    output p_gnt, p_err, p_rdata,
    input  s_req, s_sel,
    output s_gnt, s_err, s_rdata,
    input  term_clr,
    output phase, math_q, phys_q, lab_q
  );

endinterface

// File: rtl/marks_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; index 0 (principal) wins first after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  // ptr_q=0: requester 0 has priority, ptr_q=1: requester 1 has priority
  logic ptr_q, ptr_d;

  // Grant the favoured requester, or the other one when it is alone
  always_comb begin
    gnt_o[0] = req_i[0] & (~ptr_q | ~req_i[1]);
    gnt_o[1] = req_i[1] & ( ptr_q | ~req_i[0]);
    ptr_d    = ptr_q;
    if (gnt_o[0])      ptr_d = 1'b1;
    else if (gnt_o[1]) ptr_d = 1'b0;
  end

  // Pointer moves away from whoever was just served
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/marks_access_ctrl.sv
// Phase sequencer and permission checker owning the three mark registers.
//   phase   | meaning
//   ENTRY   | teacher writes marks until all three subjects are written
//   REVIEW  | principal reads any subject, may adjust lab, approves release
//   RELEASE | principal and students read, shared round-robin, no writes
module marks_access_ctrl
  import marks_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_MARK = MAX_MARK_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  marks_access_ctrl_if.slave  bus
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_MARK);

  phase_e            phase_q, phase_d;
  logic [2:0]        mask_q, mask_d;
  logic [DATA_W-1:0] math_q, math_d, phys_q, phys_d, lab_q, lab_d;
  logic              t_gnt_q, t_gnt_d, t_err_q, t_err_d;
  logic              p_gnt_q, p_gnt_d, p_err_q, p_err_d;
  logic              s_gnt_q, s_gnt_d, s_err_q, s_err_d;
  logic [DATA_W-1:0] p_rdata_q, p_rdata_d, s_rdata_q, s_rdata_d;
  logic [DATA_W-1:0] p_mark, s_mark;

  logic       t_bad, p_bad, s_bad, rel_cyc;
  logic [1:0] arb_gnt;

  // Rejects: bad subject, out-of-range data, principal writing anything
  // but lab, or principal writing once marks are released.
  assign t_bad   = (bus.t_sel == BAD) || (bus.t_wdata > MAX_V);
  assign p_bad   = (bus.p_sel == BAD) ||
                   (bus.p_we && ((bus.p_sel != LAB) || (bus.p_wdata > MAX_V) ||
                                 (phase_q == RELEASE)));
  assign s_bad   = (bus.s_sel == BAD);
  assign rel_cyc = (phase_q == RELEASE) && !bus.term_clr;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i ({rel_cyc & bus.s_req & ~s_bad, rel_cyc & bus.p_req & ~p_bad}),
    .gnt_o (arb_gnt)
  );

  // Read muxes for the two reading roles
  always_comb begin
    p_mark = '0;
    s_mark = '0;
    case (bus.p_sel)
      MATH:    p_mark = math_q;
      PHYS:    p_mark = phys_q;
      LAB:     p_mark = lab_q;
      default: p_mark = '0;
    endcase
    case (bus.s_sel)
      MATH:    s_mark = math_q;
      PHYS:    s_mark = phys_q;
      LAB:     s_mark = lab_q;
      default: s_mark = '0;
    endcase
  end

  // Next-state: term_clr overrides everything, otherwise serve by phase
  always_comb begin
    phase_d   = phase_q;
    mask_d    = mask_q;
    math_d    = math_q;
    phys_d    = phys_q;
    lab_d     = lab_q;
    t_gnt_d   = 1'b0;
    t_err_d   = 1'b0;
    p_gnt_d   = 1'b0;
    p_err_d   = 1'b0;
    s_gnt_d   = 1'b0;
    s_err_d   = 1'b0;
    p_rdata_d = p_rdata_q;
    s_rdata_d = s_rdata_q;
    if (bus.term_clr) begin
      phase_d = ENTRY;
      mask_d  = 3'b000;
      math_d  = '0;
      phys_d  = '0;
      lab_d   = '0;
    end else begin
      case (phase_q)
        ENTRY: begin
          if (bus.t_req) begin
            if (t_bad) begin
              t_err_d = 1'b1;
            end else begin
              t_gnt_d = 1'b1;
              case (bus.t_sel)
                MATH:    begin math_d = bus.t_wdata; mask_d[0] = 1'b1; end
                PHYS:    begin phys_d = bus.t_wdata; mask_d[1] = 1'b1; end
                LAB:     begin lab_d  = bus.t_wdata; mask_d[2] = 1'b1; end
                default: ;
              endcase
            end
          end
          // Valid principal/student requests simply stay pending here
          p_err_d = bus.p_req & p_bad;
          s_err_d = bus.s_req & s_bad;
          if (mask_q == 3'b111) phase_d = REVIEW;
        end
        REVIEW: begin
          t_err_d = bus.t_req;
          if (bus.p_req) begin
            if (p_bad) begin
              p_err_d = 1'b1;
            end else begin
              p_gnt_d = 1'b1;
              if (bus.p_we) lab_d     = bus.p_wdata;
              else          p_rdata_d = p_mark;
            end
          end
          s_err_d = bus.s_req & s_bad;
          if (bus.p_approve) phase_d = RELEASE;
        end
        RELEASE: begin
          t_err_d = bus.t_req;
          p_err_d = bus.p_req & p_bad;
          s_err_d = bus.s_req & s_bad;
          if (arb_gnt[0]) begin
            p_gnt_d   = 1'b1;
            p_rdata_d = p_mark;
          end
          if (arb_gnt[1]) begin
            s_gnt_d   = 1'b1;
            s_rdata_d = s_mark;
          end
        end
        default: phase_d = ENTRY;
      endcase
    end
  end

  // State, marks and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q   <= ENTRY;
      mask_q    <= 3'b000;
      math_q    <= '0;
      phys_q    <= '0;
      lab_q     <= '0;
      t_gnt_q   <= 1'b0;
      t_err_q   <= 1'b0;
      p_gnt_q   <= 1'b0;
      p_err_q   <= 1'b0;
      s_gnt_q   <= 1'b0;
      s_err_q   <= 1'b0;
      p_rdata_q <= '0;
      s_rdata_q <= '0;
    end else begin
      phase_q   <= phase_d;
      mask_q    <= mask_d;
      math_q    <= math_d;
      phys_q    <= phys_d;
      lab_q     <= lab_d;
      t_gnt_q   <= t_gnt_d;
      t_err_q   <= t_err_d;
      p_gnt_q   <= p_gnt_d;
      p_err_q   <= p_err_d;
      s_gnt_q   <= s_gnt_d;
      s_err_q   <= s_err_d;
      p_rdata_q <= p_rdata_d;
      s_rdata_q <= s_rdata_d;
    end
  end

  assign bus.t_gnt   = t_gnt_q;
  assign bus.t_err   = t_err_q;
  assign bus.p_gnt   = p_gnt_q;
  assign bus.p_err   = p_err_q;
  assign bus.p_rdata = p_rdata_q;
  assign bus.s_gnt   = s_gnt_q;
  assign bus.s_err   = s_err_q;
  assign bus.s_rdata = s_rdata_q;
  assign bus.phase   = phase_q;
  assign bus.math_q  = math_q;
  assign bus.phys_q  = phys_q;
  assign bus.lab_q   = lab_q;

endmodule

// File: tb/tb_marks_access_ctrl.sv
// Directed bench for marks_access_ctrl: phase walk, rejects, stalls,
// round-robin release reads, term clear and async reset abort.
module tb_marks_access_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  marks_access_ctrl_if #(.DATA_W(8)) bus ();

  marks_access_ctrl #(.DATA_W(8), .MAX_MARK(100)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.t_req     = 1'b0;
    bus.t_sel     = 2'd0;
    bus.t_wdata   = 8'd0;
    bus.p_req     = 1'b0;
    bus.p_we      = 1'b0;
    bus.p_sel     = 2'd0;
    bus.p_wdata   = 8'd0;
    bus.p_approve = 1'b0;
    bus.s_req     = 1'b0;
    bus.s_sel     = 2'd0;
    bus.term_clr  = 1'b0;
  endtask

  // One teacher write: request, one edge, expect the grant, drop request
  task automatic t_write(input logic [1:0] sel, input logic [7:0] val, input string tag);
    bus.t_req   = 1'b1;
    bus.t_sel   = sel;
    bus.t_wdata = val;
    step();
    chk(tag, 32'(bus.t_gnt), 1);
    bus.t_req = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst_n = 1'b0;
    #12;
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_math",  32'(bus.math_q), 0);
    chk("rst_t_gnt", 32'(bus.t_gnt), 0);
    chk("rst_prdata", 32'(bus.p_rdata), 0);
    rst_n = 1'b1;
    step();

    // ENTRY: math write, then a one-cycle pulse check
    t_write(2'd0, 8'd85, "t_gnt_math");
    chk("math_85", 32'(bus.math_q), 85);
    step();
    chk("t_gnt_pulse", 32'(bus.t_gnt), 0);

    // ENTRY: student stalls, teacher over-range write rejected
    bus.s_req = 1'b1; bus.s_sel = 2'd0;
    bus.t_req = 1'b1; bus.t_sel = 2'd1; bus.t_wdata = 8'd101;
    step();
    chk("t_err_101", 32'(bus.t_err), 1);
    chk("t_gnt_101", 32'(bus.t_gnt), 0);
    chk("s_stall_a", 32'(bus.s_gnt), 0);
    chk("phys_kept", 32'(bus.phys_q), 0);
    bus.t_req = 1'b0;
    step();
    chk("s_stall_b", 32'(bus.s_gnt), 0);
    chk("t_err_pulse", 32'(bus.t_err), 0);
    bus.s_req = 1'b0;

    // Boundary: 100 is legal
    t_write(2'd1, 8'd100, "t_gnt_p100");
    chk("phys_100", 32'(bus.phys_q), 100);
    t_write(2'd1, 8'd90, "t_gnt_phys");
    chk("phys_90", 32'(bus.phys_q), 90);
    t_write(2'd2, 8'd95, "t_gnt_lab");
    chk("lab_95", 32'(bus.lab_q), 95);
    chk("phase_still_entry", 32'(bus.phase), 0);
    step();
    chk("phase_review", 32'(bus.phase), 1);

    // REVIEW: principal read math
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_sel = 2'd0;
    step();
    chk("p_gnt_rd", 32'(bus.p_gnt), 1);
    chk("p_rdata_85", 32'(bus.p_rdata), 85);
    bus.p_req = 1'b0;
    step();
    chk("p_gnt_pulse", 32'(bus.p_gnt), 0);
    chk("p_rdata_hold", 32'(bus.p_rdata), 85);

    // REVIEW: principal write to math rejected, teacher rejected
    bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_sel = 2'd0; bus.p_wdata = 8'd70;
    bus.t_req = 1'b1; bus.t_sel = 2'd0; bus.t_wdata = 8'd10;
    step();
    chk("p_err_math", 32'(bus.p_err), 1);
    chk("p_gnt_math", 32'(bus.p_gnt), 0);
    chk("t_err_review", 32'(bus.t_err), 1);
    chk("math_kept", 32'(bus.math_q), 85);
    bus.p_req = 1'b0; bus.t_req = 1'b0;
    step();

    // REVIEW: lab write with approve in the same cycle
    bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_sel = 2'd2; bus.p_wdata = 8'd99;
    bus.p_approve = 1'b1;
    step();
    chk("p_gnt_lab", 32'(bus.p_gnt), 1);
    chk("lab_99", 32'(bus.lab_q), 99);
    chk("phase_release", 32'(bus.phase), 2);
    bus.p_req = 1'b0; bus.p_we = 1'b0; bus.p_approve = 1'b0;
    step();

    // RELEASE: both hold reads of lab, expect P,S,P,S
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_sel = 2'd2;
    bus.s_req = 1'b1; bus.s_sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_p", 32'(bus.p_gnt), (i % 2 == 0) ? 1 : 0);
      chk("rr_s", 32'(bus.s_gnt), (i % 2 == 0) ? 0 : 1);
      if (i % 2 == 0) chk("rr_prdata", 32'(bus.p_rdata), 99);
      else            chk("rr_srdata", 32'(bus.s_rdata), 99);
    end
    bus.p_req = 1'b0; bus.s_req = 1'b0;

    // RELEASE: principal write rejected
    bus.p_req = 1'b1; bus.p_we = 1'b1; bus.p_sel = 2'd2; bus.p_wdata = 8'd50;
    step();
    chk("p_err_rel", 32'(bus.p_err), 1);
    chk("lab_kept", 32'(bus.lab_q), 99);
    bus.p_req = 1'b0; bus.p_we = 1'b0;

    // RELEASE: lone student granted on consecutive cycles
    bus.s_req = 1'b1; bus.s_sel = 2'd0;
    step();
    chk("s_alone_a", 32'(bus.s_gnt), 1);
    chk("s_rdata_85", 32'(bus.s_rdata), 85);
    step();
    chk("s_alone_b", 32'(bus.s_gnt), 1);
    bus.s_req = 1'b0;

    // Term clear from RELEASE, then refill to REVIEW
    bus.term_clr = 1'b1;
    step();
    chk("clr_phase", 32'(bus.phase), 0);
    chk("clr_lab", 32'(bus.lab_q), 0);
    bus.term_clr = 1'b0;
    t_write(2'd0, 8'd1, "refill_m");
    t_write(2'd1, 8'd2, "refill_p");
    t_write(2'd2, 8'd3, "refill_l");
    step();
    chk("refill_review", 32'(bus.phase), 1);

    // term_clr beats p_approve and a principal read
    bus.term_clr = 1'b1; bus.p_approve = 1'b1;
    bus.p_req = 1'b1; bus.p_we = 1'b0; bus.p_sel = 2'd0;
    step();
    chk("tc_no_gnt", 32'(bus.p_gnt), 0);
    chk("tc_phase", 32'(bus.phase), 0);
    chk("tc_math", 32'(bus.math_q), 0);
    chk("tc_phys", 32'(bus.phys_q), 0);
    bus.term_clr = 1'b0; bus.p_approve = 1'b0;
    step();
    chk("tc_p_stall", 32'(bus.p_gnt), 0);
    chk("tc_p_noerr", 32'(bus.p_err), 0);
    bus.p_req = 1'b0;

    // Mask cleared: one write must not move to REVIEW
    t_write(2'd0, 8'd12, "post_clr_m");
    step();
    step();
    chk("mask_cleared", 32'(bus.phase), 0);

    // Async reset mid-cycle during a pending teacher write
    bus.t_req = 1'b1; bus.t_sel = 2'd1; bus.t_wdata = 8'd44;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_math", 32'(bus.math_q), 0);
    chk("arst_phase", 32'(bus.phase), 0);
    chk("arst_t_gnt", 32'(bus.t_gnt), 0);
    step();
    chk("arst_no_gnt", 32'(bus.t_gnt), 0);
    chk("arst_phys", 32'(bus.phys_q), 0);
    bus.t_req = 1'b0;
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
